pcs_traffic_gen: RTL and testbench

Synthesizable, parametrised traffic generator and loopback checker for the PCS subsystem. It replaces hand-written GMII-side stimulus sequences.
- Transmit side: drives tx_en/txd with N programmable frames (length, payload mode, seed, inter-frame gap).
- Receive side: compares rxd/rx_dv/rx_er against the transmitted bytes using an expected-data FIFO, and keeps error and frame counters.
- Placement: on the GMII side of the full PCS (transmit → PMA loopback → receive).

---
 rtl/pcs_tg_defs.sv | 22 ++
 rtl/pcs_tg_fifo.sv | 46 ++++
 rtl/pcs_traffic_gen.sv | 241 ++++++++++++++++++++++++
 tb/tb_pcs_traffic_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_tg_defs.sv
// Shared encodings for the PCS traffic generator: payload modes, FSM states and LFSR constants.
package pcs_tg_defs;

   typedef enum logic [1:0] {
      TG_MODE_INC   = 2'd0,
      TG_MODE_PRBS  = 2'd1,
      TG_MODE_FIXED = 2'd2,
      TG_MODE_RSVD  = 2'd3
   } tg_mode_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSend   = 2'd1,
      StGap    = 2'd2,
      StFinish = 2'd3
   } tg_state_e;

   // x^8+x^6+x^5+x^4+1 in left-shifting Fibonacci form taps state bits 7,5,4,3
   localparam logic [7:0] TG_LFSR_TAPS         = 8'hB8;
   localparam logic [7:0] TG_LFSR_DEFAULT_SEED = 8'h01;

endpackage

// File: rtl/pcs_tg_fifo.sv
// Synchronous expected-data FIFO; a push while full is accepted only when a pop frees a slot.
module pcs_tg_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/pcs_traffic_gen.sv
// GMII-side frame generator and loopback checker for the PCS.
// Define ERR_INJECT_EN to add inj_en/inj_pos, which flip bit 0 of one byte per frame.
module pcs_traffic_gen
   import pcs_tg_defs::*;
#(
   parameter int unsigned OCTET_WIDTH = 8,
   parameter int unsigned LEN_WIDTH   = 6,
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH  = 32,
   parameter int unsigned MIN_IFG     = 3
) (
   input  logic                   clk,
   input  logic                   mr_main_reset,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [OCTET_WIDTH-1:0] seed,
   input  logic [LEN_WIDTH-1:0]   frame_len,
   input  logic [LEN_WIDTH-1:0]   ifg_len,
   input  logic [CNT_WIDTH-1:0]   num_frames,
`ifdef ERR_INJECT_EN
   input  logic                   inj_en,
   input  logic [LEN_WIDTH-1:0]   inj_pos,
`endif
   output logic                   tx_en,
   output logic [OCTET_WIDTH-1:0] txd,
   output logic                   busy,
   output logic                   done,
   input  logic [OCTET_WIDTH-1:0] rxd,
   input  logic                   rx_dv,
   input  logic                   rx_er,
   output logic [CNT_WIDTH-1:0]   err_count,
   output logic [CNT_WIDTH-1:0]   rxer_count,
   output logic [CNT_WIDTH-1:0]   rx_frames,
   output logic                   fifo_ovf,
   output logic                   fifo_unf
);

   localparam int unsigned OW = OCTET_WIDTH;
   localparam int unsigned LW = LEN_WIDTH;
   localparam logic [OW-1:0] TapMask  = OW'(TG_LFSR_TAPS);
   localparam logic [OW-1:0] DefSeed  = OW'(TG_LFSR_DEFAULT_SEED);

   tg_state_e          state;
   logic [1:0]         mode_q;
   logic [OW-1:0]      seed_q, lfsr_q, txd_clean_q;
   logic [LW-1:0]      len_q, gap_q, gap_cnt_q, idx_q;
   logic [CNT_WIDTH-1:0] frames_left_q;
   logic               tx_en_q, corrupt_q, busy_q, done_q;

   logic               accept;
   logic [LW-1:0]      ifg_eff, idx_nxt;
   logic [OW-1:0]      start_seed, frame_seed, lfsr_nxt;
   logic [OW-1:0]      start_byte, frame_byte, next_byte;
   logic               inj_start, inj_frame, inj_next;

   function automatic logic [OW-1:0] lfsr_load(input logic [OW-1:0] s);
      return (s == '0) ? DefSeed : s;
   endfunction

   // PRBS falls back to the incrementing pattern when the octet is not 8 bits
   function automatic logic [OW-1:0] payload(input logic [1:0] m, input logic [OW-1:0] s,
                                             input logic [OW-1:0] lfsr, input logic [LW-1:0] k);
      if (m == TG_MODE_PRBS && OCTET_WIDTH == 8) return lfsr;
      else if (m == TG_MODE_FIXED)               return s;
      else                                       return s + OW'(k);
   endfunction

   assign accept     = (state == StIdle) && start;
   assign ifg_eff    = (ifg_len < LW'(MIN_IFG)) ? LW'(MIN_IFG) : ifg_len;
   assign idx_nxt    = idx_q + 1'b1;
   assign start_seed = lfsr_load(seed);
   assign frame_seed = lfsr_load(seed_q);
   assign lfsr_nxt   = {lfsr_q[OW-2:0], ^(lfsr_q & TapMask)};
   assign start_byte = payload(mode, seed, start_seed, '0);
   assign frame_byte = payload(mode_q, seed_q, frame_seed, '0);
   assign next_byte  = payload(mode_q, seed_q, lfsr_nxt, idx_nxt);

`ifdef ERR_INJECT_EN
   logic          inj_en_q;
   logic [LW-1:0] inj_pos_q;

   always_ff @(posedge clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         inj_en_q  <= 1'b0;
         inj_pos_q <= '0;
      end else if (accept) begin
         inj_en_q  <= inj_en;
         inj_pos_q <= inj_pos;
      end
   end

   assign inj_start = inj_en && (inj_pos == '0);
   assign inj_frame = inj_en_q && (inj_pos_q == '0);
   assign inj_next  = inj_en_q && (inj_pos_q == idx_nxt);
`else
   assign inj_start = 1'b0;
   assign inj_frame = 1'b0;
   assign inj_next  = 1'b0;
`endif

   always_ff @(posedge clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         state         <= StIdle;
         mode_q        <= '0;
         seed_q        <= '0;
         len_q         <= '0;
         gap_q         <= '0;
         gap_cnt_q     <= '0;
         idx_q         <= '0;
         frames_left_q <= '0;
         lfsr_q        <= '0;
         txd_clean_q   <= '0;
         tx_en_q       <= 1'b0;
         corrupt_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  mode_q        <= mode;
                  seed_q        <= seed;
                  len_q         <= (frame_len == '0) ? LW'(1) : frame_len;
                  gap_q         <= ifg_eff - LW'(1);
                  frames_left_q <= num_frames;
                  busy_q        <= 1'b1;
                  if (num_frames != '0) begin
                     state       <= StSend;
                     tx_en_q     <= 1'b1;
                     txd_clean_q <= start_byte;
                     corrupt_q   <= inj_start;
                     lfsr_q      <= start_seed;
                     idx_q       <= '0;
                  end else begin
                     state <= StFinish;
                  end
               end
            end
            StSend: begin
               if (idx_q == len_q - LW'(1)) begin
                  tx_en_q     <= 1'b0;
                  txd_clean_q <= '0;
                  corrupt_q   <= 1'b0;
                  if (frames_left_q == CNT_WIDTH'(1)) begin
                     state <= StFinish;
                  end else begin
                     frames_left_q <= frames_left_q - 1'b1;
                     gap_cnt_q     <= gap_q;
                     state         <= StGap;
                  end
               end else begin
                  idx_q       <= idx_nxt;
                  lfsr_q      <= lfsr_nxt;
                  txd_clean_q <= next_byte;
                  corrupt_q   <= inj_next;
               end
            end
            StGap: begin
               if (gap_cnt_q == '0) begin
                  state       <= StSend;
                  tx_en_q     <= 1'b1;
                  txd_clean_q <= frame_byte;
                  corrupt_q   <= inj_frame;
                  lfsr_q      <= frame_seed;
                  idx_q       <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            StFinish: begin
               state  <= StIdle;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign tx_en = tx_en_q;
   assign txd   = txd_clean_q ^ {{(OW-1){1'b0}}, corrupt_q};
   assign busy  = busy_q;
   assign done  = done_q;

   // The FIFO holds the clean byte so injected corruption shows up as a mismatch
   logic [OW-1:0] fifo_head;
   logic          fifo_full, fifo_empty, fifo_pop;

   assign fifo_pop = rx_dv && !fifo_empty;

   pcs_tg_fifo #(
      .WIDTH(OCTET_WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (mr_main_reset),
      .push     (tx_en_q),
      .push_data(txd_clean_q),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   logic [CNT_WIDTH-1:0] err_q, rxer_q, frames_q;
   logic                 ovf_q, unf_q, rx_dv_q;

   always_ff @(posedge clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         err_q    <= '0;
         rxer_q   <= '0;
         frames_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rx_dv_q  <= 1'b0;
      end else begin
         rx_dv_q <= rx_dv;
         if (accept) begin
            err_q    <= '0;
            rxer_q   <= '0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
         end else begin
            if (rx_dv && (fifo_empty || fifo_head != rxd) && err_q != '1) err_q <= err_q + 1'b1;
            if (rx_dv && fifo_empty)                    unf_q    <= 1'b1;
            if (tx_en_q && fifo_full && !fifo_pop)      ovf_q    <= 1'b1;
            if (rx_er && rxer_q != '1)                  rxer_q   <= rxer_q + 1'b1;
            if (rx_dv_q && !rx_dv && frames_q != '1)    frames_q <= frames_q + 1'b1;
         end
      end
   end

   assign err_count  = err_q;
   assign rxer_count = rxer_q;
   assign rx_frames  = frames_q;
   assign fifo_ovf   = ovf_q;
   assign fifo_unf   = unf_q;

endmodule

// File: tb/tb_pcs_traffic_gen.sv
// Self-checking bench for pcs_traffic_gen with a delayed txd->rxd loopback and a small-FIFO twin.
module tb_pcs_traffic_gen;
   import pcs_tg_defs::*;

   logic       clk = 1'b0;
   logic       mr_main_reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] seed = '0;
   logic [5:0] frame_len = '0, ifg_len = '0;
   logic [7:0] num_frames = '0;
`ifdef ERR_INJECT_EN
   logic       inj_en = 1'b0;
   logic [5:0] inj_pos = '0;
`endif
   logic       tx_en, busy, done, fifo_ovf, fifo_unf, rx_dv, rx_er;
   logic [7:0] txd, rxd, err_count, rxer_count, rx_frames;
   logic       s_tx_en, s_busy, s_done, s_ovf, s_unf, s_rx_dv;
   logic [7:0] s_txd, s_rxd, s_err, s_rxer, s_frames;

   // Loopback and manual rx controls
   logic       loop_en = 1'b1, loop_clr = 1'b0;
   int         loop_delay = 6, flip_idx = -1, rx_byte_cnt = 0;
   logic       man_dv = 1'b0, man_er = 1'b0;
   logic [7:0] man_d = '0;
   logic       dv_line [64];
   logic [7:0] d_line [64];
   logic       sdv_line [64];
   logic [7:0] sd_line [64];
   logic       loop_dv;

   int n_checks = 0, n_fail = 0;
   logic [7:0] obs_bytes[$], exp_q[$];
   int         obs_gaps[$];
   int         done_cnt, post_done_tx;
   bit         timed_out;
   logic       busy_end;

   always #5 clk = ~clk;

   pcs_traffic_gen dut (
      .clk(clk), .mr_main_reset(mr_main_reset), .start(start), .mode(mode), .seed(seed),
      .frame_len(frame_len), .ifg_len(ifg_len), .num_frames(num_frames),
`ifdef ERR_INJECT_EN
      .inj_en(inj_en), .inj_pos(inj_pos),
`endif
      .tx_en(tx_en), .txd(txd), .busy(busy), .done(done), .rxd(rxd), .rx_dv(rx_dv),
      .rx_er(rx_er), .err_count(err_count), .rxer_count(rxer_count), .rx_frames(rx_frames),
      .fifo_ovf(fifo_ovf), .fifo_unf(fifo_unf)
   );

   pcs_traffic_gen #(.FIFO_DEPTH(4)) dut_small (
      .clk(clk), .mr_main_reset(mr_main_reset), .start(start), .mode(mode), .seed(seed),
      .frame_len(frame_len), .ifg_len(ifg_len), .num_frames(num_frames),
`ifdef ERR_INJECT_EN
      .inj_en(inj_en), .inj_pos(inj_pos),
`endif
      .tx_en(s_tx_en), .txd(s_txd), .busy(s_busy), .done(s_done), .rxd(s_rxd),
      .rx_dv(s_rx_dv), .rx_er(1'b0), .err_count(s_err), .rxer_count(s_rxer),
      .rx_frames(s_frames), .fifo_ovf(s_ovf), .fifo_unf(s_unf)
   );

   always @(posedge clk) begin
      dv_line[0]  <= tx_en;
      d_line[0]   <= txd;
      sdv_line[0] <= s_tx_en;
      sd_line[0]  <= s_txd;
      for (int i = 1; i < 64; i++) begin
         dv_line[i]  <= dv_line[i-1];
         d_line[i]   <= d_line[i-1];
         sdv_line[i] <= sdv_line[i-1];
         sd_line[i]  <= sd_line[i-1];
      end
      if (loop_clr) rx_byte_cnt <= 0;
      else if (loop_dv) rx_byte_cnt <= rx_byte_cnt + 1;
   end

   always_comb begin
      loop_dv = dv_line[loop_delay-1] === 1'b1;
      rx_dv   = loop_en ? loop_dv : man_dv;
      rxd     = loop_en ? (d_line[loop_delay-1] ^ ((rx_byte_cnt == flip_idx) ? 8'h01 : 8'h00))
                        : man_d;
      rx_er   = man_er;
      s_rx_dv = sdv_line[39] === 1'b1;
      s_rxd   = sd_line[39];
   end

   function automatic logic [7:0] model_byte(input logic [1:0] m, input logic [7:0] s,
                                             input int k);
      logic [7:0] l;
      l = (s == 8'h00) ? 8'h01 : s;
      if (m == 2'd1) begin
         for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
         return l;
      end
      if (m == 2'd2) return s;
      return s + 8'(k);
   endfunction

   task automatic drain(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_loop();
      loop_clr = 1'b1; @(posedge clk); #1; loop_clr = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [7:0] s, input logic [5:0] len,
                              input logic [5:0] ifg, input logic [7:0] nf);
      @(negedge clk);
      mode = m; seed = s; frame_len = len; ifg_len = ifg; num_frames = nf; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Collects txd bytes, gap lengths and done pulses; optionally re-pulses start mid-run
   task automatic capture_run(input int max_cycles, input int restart_at);
      int gap = 0, after = -1;
      bit in_gap = 0, prev_en = 0;
      obs_bytes.delete(); obs_gaps.delete();
      done_cnt = 0; post_done_tx = 0; timed_out = 1;
      for (int c = 0; c < max_cycles; c++) begin
         if (c == restart_at) begin start = 1'b1; seed = 8'h77; num_frames = 8'd3; end
         else start = 1'b0;
         if (tx_en) begin
            if (done_cnt > 0) post_done_tx++;
            obs_bytes.push_back(txd);
            if (in_gap) obs_gaps.push_back(gap);
            in_gap = 0;
         end else if (prev_en) begin
            in_gap = 1; gap = 1;
         end else if (in_gap) gap++;
         prev_en = tx_en;
         if (done) begin done_cnt++; if (after < 0) after = 0; end
         if (after >= 0) begin
            after++;
            if (after > 5) begin timed_out = 0; break; end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      busy_end = busy;
   endtask

   task automatic test_reset();
      drain(3);
      n_checks++;
      if ({tx_en, txd, busy, done} !== 11'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %b, expected all zero", {tx_en, txd, busy, done});
      end
      n_checks++;
      if ({err_count, rxer_count, rx_frames, fifo_ovf, fifo_unf} !== 26'd0) begin
         n_fail++; $display("FAIL reset_counters: got err=%0d rxer=%0d frames=%0d ovf=%b unf=%b, expected zeros",
                            err_count, rxer_count, rx_frames, fifo_ovf, fifo_unf);
      end
      @(negedge clk); mr_main_reset = 1'b0;
      drain(2);
      n_checks++;
      if (dut.state !== StIdle || busy !== 1'b0 || tx_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: state=%0d busy=%b tx_en=%b, expected idle/0/0",
                            dut.state, busy, tx_en);
      end
   endtask

   task automatic test_mode_inc();
      logic [7:0] e, g;
      drain(60); clear_loop();
      for (int f = 0; f < 2; f++) for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
      pulse_start(2'd0, 8'h10, 6'd4, 6'd7, 8'd2);
      capture_run(200, -1);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL inc_done_seen: got 0, expected 1"); end
      n_checks++;
      if (obs_bytes.size() != exp_q.size()) begin
         n_fail++; $display("FAIL inc_nbytes: got %0d, expected %0d", obs_bytes.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_bytes.size() > 0) begin
         e = exp_q.pop_front(); g = obs_bytes.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL inc_byte: got %h, expected %h", g, e); end
      end
      exp_q.delete();
      n_checks++;
      if (obs_gaps.size() != 1 || obs_gaps[0] != 7) begin
         n_fail++; $display("FAIL inc_gap: got n=%0d first=%0d, expected one gap of 7",
                            obs_gaps.size(), (obs_gaps.size() > 0) ? obs_gaps[0] : -1);
      end
      n_checks++;
      if (done_cnt != 1 || busy_end !== 1'b0) begin
         n_fail++; $display("FAIL inc_done_busy: got done=%0d busy=%b, expected 1/0", done_cnt, busy_end);
      end
      drain(12);
      n_checks++;
      if (err_count !== 8'd0 || rx_frames !== 8'd2) begin
         n_fail++; $display("FAIL inc_loop: got err=%0d frames=%0d, expected 0/2", err_count, rx_frames);
      end
   endtask

   task automatic test_mode_prbs();
      logic [7:0] e, g;
      logic [7:0] ref_seq [5];
      ref_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      drain(60); clear_loop();
      for (int k = 0; k < 5; k++) exp_q.push_back(ref_seq[k]);
      pulse_start(2'd1, 8'h01, 6'd5, 6'd3, 8'd1);
      capture_run(200, -1);
      n_checks++;
      if (obs_bytes.size() != exp_q.size()) begin
         n_fail++; $display("FAIL prbs_nbytes: got %0d, expected %0d", obs_bytes.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_bytes.size() > 0) begin
         e = exp_q.pop_front(); g = obs_bytes.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL prbs_byte: got %h, expected %h", g, e); end
      end
      exp_q.delete();
      drain(12);
      n_checks++;
      if (err_count !== 8'd0 || rx_frames !== 8'd1 || fifo_unf !== 1'b0) begin
         n_fail++; $display("FAIL prbs_loop: got err=%0d frames=%0d unf=%b, expected 0/1/0",
                            err_count, rx_frames, fifo_unf);
      end
   endtask

   task automatic test_fixed_reserved();
      logic [7:0] e, g;
      logic [1:0] tm [4];
      logic [7:0] ts [4];
      logic [5:0] tl [4];
      tm = '{2'd2, 2'd3, 2'd0, 2'd1};
      ts = '{8'hA5, 8'hFE, 8'h07, 8'h00};
      tl = '{6'd3, 6'd3, 6'd0, 6'd6};
      for (int t = 0; t < 4; t++) begin
         drain(20); clear_loop();
         for (int k = 0; k < ((tl[t] == 0) ? 1 : int'(tl[t])); k++)
            exp_q.push_back(model_byte(tm[t], ts[t], k));
         pulse_start(tm[t], ts[t], tl[t], 6'd3, 8'd1);
         capture_run(200, -1);
         n_checks++;
         if (obs_bytes.size() != exp_q.size()) begin
            n_fail++; $display("FAIL table%0d_nbytes: got %0d, expected %0d", t, obs_bytes.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_bytes.size() > 0) begin
            e = exp_q.pop_front(); g = obs_bytes.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL table%0d_byte: got %h, expected %h", t, g, e); end
         end
         exp_q.delete();
      end
   endtask

   task automatic test_min_ifg();
      drain(20); clear_loop();
      pulse_start(2'd0, 8'h40, 6'd2, 6'd0, 8'd3);
      capture_run(200, -1);
      n_checks++;
      if (obs_bytes.size() != 6) begin
         n_fail++; $display("FAIL minifg_nbytes: got %0d, expected 6", obs_bytes.size());
      end
      n_checks++;
      if (obs_gaps.size() != 2 || obs_gaps[0] != 3 || obs_gaps[1] != 3) begin
         n_fail++; $display("FAIL minifg_gaps: got n=%0d, expected two gaps of 3", obs_gaps.size());
      end
   endtask

   task automatic test_zero_frames();
      drain(20);
      pulse_start(2'd0, 8'h00, 6'd4, 6'd3, 8'd0);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || tx_en !== 1'b0) begin
         n_fail++; $display("FAIL zero_c1: got done=%b busy=%b tx_en=%b, expected 0/1/0", done, busy, tx_en);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || tx_en !== 1'b0) begin
         n_fail++; $display("FAIL zero_c2: got done=%b busy=%b tx_en=%b, expected 1/0/0", done, busy, tx_en);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL zero_c3: got done=%b, expected 0", done); end
   endtask

   task automatic test_flip();
      drain(20); clear_loop();
      flip_idx = 1;
      pulse_start(2'd2, 8'h5A, 6'd4, 6'd3, 8'd1);
      capture_run(200, -1);
      drain(12);
      n_checks++;
      if (err_count !== 8'd1 || rx_frames !== 8'd1) begin
         n_fail++; $display("FAIL flip_err: got err=%0d frames=%0d, expected 1/1", err_count, rx_frames);
      end
      flip_idx = -1;
   endtask

   task automatic test_underflow();
      drain(20);
      loop_en = 1'b0;
      pulse_start(2'd0, 8'h00, 6'd1, 6'd3, 8'd0);
      @(negedge clk); man_dv = 1'b1; man_d = 8'h33; man_er = 1'b1;
      @(negedge clk); man_dv = 1'b0;
      @(negedge clk); @(negedge clk); man_er = 1'b0;
      drain(3);
      n_checks++;
      if (fifo_unf !== 1'b1 || err_count !== 8'd1) begin
         n_fail++; $display("FAIL unf: got unf=%b err=%0d, expected 1/1", fifo_unf, err_count);
      end
      n_checks++;
      if (rxer_count !== 8'd3 || rx_frames !== 8'd1 || fifo_ovf !== 1'b0) begin
         n_fail++; $display("FAIL unf_misc: got rxer=%0d frames=%0d ovf=%b, expected 3/1/0",
                            rxer_count, rx_frames, fifo_ovf);
      end
   endtask

   task automatic test_saturation();
      pulse_start(2'd0, 8'h00, 6'd1, 6'd3, 8'd0);
      @(negedge clk); man_er = 1'b1;
      repeat (300) @(negedge clk);
      man_er = 1'b0;
      drain(2);
      n_checks++;
      if (rxer_count !== 8'd255) begin
         n_fail++; $display("FAIL rxer_sat: got %0d, expected 255", rxer_count);
      end
      loop_en = 1'b1;
   endtask

   task automatic test_overflow();
      drain(60); clear_loop();
      pulse_start(2'd0, 8'h00, 6'd20, 6'd3, 8'd2);
      capture_run(200, -1);
      n_checks++;
      if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL small_ovf: got %b, expected 1", s_ovf); end
      n_checks++;
      if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL main_no_ovf: got %b, expected 0", fifo_ovf); end
      drain(60);
   endtask

   task automatic test_start_while_busy();
      logic [7:0] e, g;
      drain(20); clear_loop();
      for (int k = 0; k < 8; k++) exp_q.push_back(8'h20 + 8'(k));
      pulse_start(2'd0, 8'h20, 6'd8, 6'd3, 8'd1);
      capture_run(200, 3);
      drain(10);
      n_checks++;
      if (obs_bytes.size() != exp_q.size() || done_cnt != 1 || post_done_tx != 0 || tx_en !== 1'b0) begin
         n_fail++; $display("FAIL busy_restart: got bytes=%0d done=%0d post=%0d, expected 8/1/0",
                            obs_bytes.size(), done_cnt, post_done_tx);
      end
      while (exp_q.size() > 0 && obs_bytes.size() > 0) begin
         e = exp_q.pop_front(); g = obs_bytes.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL busy_byte: got %h, expected %h", g, e); end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_send();
      drain(20); clear_loop();
      man_er = 1'b1;
      pulse_start(2'd0, 8'h00, 6'd20, 6'd3, 8'd1);
      drain(3);
      n_checks++;
      if (tx_en !== 1'b1 || rxer_count !== 8'd3) begin
         n_fail++; $display("FAIL pre_reset: got tx_en=%b rxer=%0d, expected 1/3", tx_en, rxer_count);
      end
      #2 mr_main_reset = 1'b1;
      #1;
      n_checks++;
      if (tx_en !== 1'b0 || txd !== 8'h00 || busy !== 1'b0 || dut.state !== StIdle) begin
         n_fail++; $display("FAIL async_reset_tx: got tx_en=%b txd=%h busy=%b state=%0d, expected 0/00/0/idle",
                            tx_en, txd, busy, dut.state);
      end
      n_checks++;
      if (rxer_count !== 8'd0 || err_count !== 8'd0 || rx_frames !== 8'd0) begin
         n_fail++; $display("FAIL async_reset_cnt: got rxer=%0d err=%0d frames=%0d, expected 0",
                            rxer_count, err_count, rx_frames);
      end
      man_er = 1'b0;
      @(negedge clk); mr_main_reset = 1'b0;
   endtask

`ifdef ERR_INJECT_EN
   task automatic test_inject();
      drain(60); clear_loop();
      inj_en = 1'b1; inj_pos = 6'd2;
      pulse_start(2'd0, 8'h00, 6'd4, 6'd3, 8'd3);
      inj_en = 1'b0;
      capture_run(200, -1);
      drain(12);
      n_checks++;
      if (err_count !== 8'd3) begin n_fail++; $display("FAIL inject_err: got %0d, expected 3", err_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_mode_inc();
      test_mode_prbs();
      test_fixed_reserved();
      test_min_ifg();
      test_zero_frames();
      test_flip();
      test_underflow();
      test_saturation();
      test_overflow();
      test_start_while_busy();
      test_reset_mid_send();
`ifdef ERR_INJECT_EN
      test_inject();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
